// File: rtl/carfield_decerr_resp.sv
// carfield_decerr_resp: address-decode error responder for the Carfield memory map.
// Accepts one request at a time. It classifies the address as OK, DISABLED, UNMAPPED
// or MISALIGNED and returns a single registered response.
// Optional error log (counter and last error address) is built only when the
// macro CARFIELD_DECERR_LOG_EN is defined.
module carfield_decerr_resp #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned DataWidth    = 32,
    parameter logic [7:0]  RegionEnable = 8'b1011_0011,
    parameter logic [31:0] ErrData      = 32'hBADC_AB1E
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [1:0]           rsp_code_o,
    output logic [2:0]           rsp_region_o,
    output logic [DataWidth-1:0] rsp_rdata_o,
    input  logic                 clear_i,
    output logic [15:0]          err_cnt_o,
    output logic [AddrWidth-1:0] last_err_addr_o
);

    localparam logic [1:0] CODE_OK         = 2'b00;
    localparam logic [1:0] CODE_DISABLED   = 2'b01;
    localparam logic [1:0] CODE_UNMAPPED   = 2'b10;
    localparam logic [1:0] CODE_MISALIGNED = 2'b11;

    // Compare width wide enough to hold base+size (33 bits) and the full address,
    // so that upper address bits take part in the decode.
    localparam int unsigned CmpWidth = (AddrWidth > 33) ? AddrWidth : 33;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    function automatic logic [31:0] region_base(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h7800_0000;
            3'd1:    return 32'h7820_0000;
            3'd2:    return 32'h6000_0000;
            3'd3:    return 32'h2000_0000;
            3'd4:    return 32'h2000_1000;
            3'd5:    return 32'h5100_0000;
            3'd6:    return 32'h5000_0000;
            3'd7:    return 32'h4000_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] region_size(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h0020_0000;
            3'd1:    return 32'h0020_0000;
            3'd2:    return 32'h0080_0000;
            3'd3:    return 32'h0000_1000;
            3'd4:    return 32'h0000_9000;
            3'd5:    return 32'h0080_0000;
            3'd6:    return 32'h0080_0000;
            3'd7:    return 32'h0000_1000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Half-open window test [base, base+size).
    function automatic logic in_region(input logic [AddrWidth-1:0] addr, input logic [2:0] idx);
        logic [CmpWidth-1:0] a_ext;
        logic [CmpWidth-1:0] lo_ext;
        logic [CmpWidth-1:0] hi_ext;
        a_ext  = CmpWidth'(addr);
        lo_ext = CmpWidth'(region_base(idx));
        hi_ext = CmpWidth'({1'b0, region_base(idx)} + {1'b0, region_size(idx)});
        return (a_ext >= lo_ext) && (a_ext < hi_ext);
    endfunction

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [1:0]             code_q, code_d;
    logic [2:0]             region_q, region_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   hit_s;
    logic [2:0]             hit_idx_s;
    logic [1:0]             code_s;
    logic                   req_hs_s;

    assign req_hs_s = req_valid_i && ready_q;

    // Region decode: scan high to low so the lowest matching index wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (in_region(req_addr_i, 3'(i))) begin
                hit_s     = 1'b1;
                hit_idx_s = 3'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
        if (req_addr_i[1:0] != 2'b00) begin
            code_s = CODE_MISALIGNED;
        end else if (!hit_s) begin
            code_s = CODE_UNMAPPED;
        end else if (!RegionEnable[hit_idx_s]) begin
            code_s = CODE_DISABLED;
        end else begin
            code_s = CODE_OK;
        end
    end

    // Next-state logic for the IDLE/RESP handshake FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_hs_s) begin
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/capture logic: handshake flags follow the next state, payload loads on accept.
    always_comb begin
        ready_d  = (state_d == IDLE);
        valid_d  = (state_d == RESP);
        code_d   = code_q;
        region_d = region_q;
        rdata_d  = rdata_q;
        if (req_hs_s) begin
            code_d   = code_s;
            region_d = hit_s ? hit_idx_s : 3'd0;
            rdata_d  = (code_s == CODE_OK) ? {DataWidth{1'b0}} : DataWidth'(ErrData);
        end else begin
            code_d   = code_q;
            region_d = region_q;
            rdata_d  = rdata_q;
        end
    end

    // State and response registers; reset drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            code_q   <= 2'b00;
            region_q <= 3'd0;
            rdata_q  <= {DataWidth{1'b0}};
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            region_q <= region_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = valid_q;
    assign rsp_code_o   = code_q;
    assign rsp_region_o = region_q;
    assign rsp_rdata_o  = rdata_q;

`ifdef CARFIELD_DECERR_LOG_EN
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [AddrWidth-1:0] last_err_addr_q, last_err_addr_d;
    logic                 err_hs_s;
    logic                 unused_s;

    assign unused_s = req_write_i;
    assign err_hs_s = valid_q && rsp_ready_i && (code_q != CODE_OK);

    // Error log update: clear has priority, counter saturates at all-ones.
    always_comb begin
        addr_d          = req_hs_s ? req_addr_i : addr_q;
        err_cnt_d       = err_cnt_q;
        last_err_addr_d = last_err_addr_q;
        if (clear_i) begin
            err_cnt_d       = 16'h0000;
            last_err_addr_d = {AddrWidth{1'b0}};
        end else if (err_hs_s) begin
            err_cnt_d       = (err_cnt_q == 16'hFFFF) ? 16'hFFFF : (err_cnt_q + 16'h0001);
            last_err_addr_d = addr_q;
        end else begin
            err_cnt_d       = err_cnt_q;
            last_err_addr_d = last_err_addr_q;
        end
    end

    // Error log registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q          <= {AddrWidth{1'b0}};
            err_cnt_q       <= 16'h0000;
            last_err_addr_q <= {AddrWidth{1'b0}};
        end else begin
            addr_q          <= addr_d;
            err_cnt_q       <= err_cnt_d;
            last_err_addr_q <= last_err_addr_d;
        end
    end

    assign err_cnt_o       = err_cnt_q;
    assign last_err_addr_o = last_err_addr_q;
`else
    logic unused_s;

    assign unused_s        = req_write_i ^ clear_i;
    assign err_cnt_o       = 16'h0000;
    assign last_err_addr_o = {AddrWidth{1'b0}};
`endif

endmodule

// File: tb/tb_carfield_decerr_resp.sv
// Testbench for carfield_decerr_resp: directed map/boundary cases, stalls, log
// saturation and clear, reset mid-response, and randomized traffic against a
// table-driven reference model of the address map.
module tb_carfield_decerr_resp;

    localparam logic [31:0] BASE [0:7] = '{32'h7800_0000, 32'h7820_0000, 32'h6000_0000, 32'h2000_0000,
                                           32'h2000_1000, 32'h5100_0000, 32'h5000_0000, 32'h4000_0000};
    localparam logic [31:0] SIZE [0:7] = '{32'h0020_0000, 32'h0020_0000, 32'h0080_0000, 32'h0000_1000,
                                           32'h0000_9000, 32'h0080_0000, 32'h0080_0000, 32'h0000_1000};
    localparam logic [7:0]  EN      = 8'b1011_0011;
    localparam logic [31:0] BAD     = 32'hBADC_AB1E;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic        req_write_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_code_o;
    logic [2:0]  rsp_region_o;
    logic [31:0] rsp_rdata_o;
    logic        clear_i;
    logic [15:0] err_cnt_o;
    logic [63:0] last_err_addr_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_cnt  = 16'h0000;
    logic [63:0] m_last = 64'h0;

    always #5 clk_i = ~clk_i;

    carfield_decerr_resp dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_write_i     (req_write_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_code_o      (rsp_code_o),
        .rsp_region_o    (rsp_region_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .clear_i         (clear_i),
        .err_cnt_o       (err_cnt_o),
        .last_err_addr_o (last_err_addr_o)
    );

    // Reference: first region (lowest index) containing the address, then the priority rules.
    function automatic void ref_decode(input logic [63:0] a, output logic [1:0] code,
                                       output logic [2:0] rgn, output logic [31:0] data);
        int hit;
        logic [63:0] lo;
        logic [63:0] hi;
        hit = -1;
        for (int i = 0; i < 8; i++) begin
            lo = {32'h0, BASE[i]};
            hi = lo + {32'h0, SIZE[i]};
            if (hit < 0 && a >= lo && a < hi) hit = i;
        end
        rgn = (hit < 0) ? 3'd0 : 3'(hit);
        if (a[1:0] != 2'b00)   code = 2'b11;
        else if (hit < 0)      code = 2'b10;
        else if (EN[hit])      code = 2'b00;
        else                   code = 2'b01;
        data = (code == 2'b00) ? 32'h0 : BAD;
    endfunction

    function automatic logic [63:0] rand_addr();
        int k;
        logic [31:0] b;
        logic [31:0] s;
        k = $urandom_range(0, 7);
        b = BASE[k];
        s = SIZE[k];
        case ($urandom_range(0, 6))
            0:       return {32'h0, b + (($urandom % s) & 32'hFFFF_FFFC)};
            1:       return {32'h0, b + s - 32'd4};
            2:       return {32'h0, b + s};
            3:       return {32'h0, $urandom};
            4:       return {32'($urandom_range(1, 32'hFFFF)), b};
            5:       return {32'h0, b | 32'($urandom_range(1, 3))};
            default: return {32'h0, b - 32'd4};
        endcase
    endfunction

    // One full transaction: accept, check payload, stall `hold` cycles, complete, check log.
    // lit[2] set means also compare the code to the literal lit[1:0].
    task automatic do_txn(input logic [63:0] addr, input int hold, input logic clr,
                          input logic [2:0] lit, input string tag);
        logic [1:0]  ec;
        logic [2:0]  er;
        logic [31:0] ed;
        int          wait_n;
        ref_decode(addr, ec, er, ed);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_write_i = 1'($urandom_range(0, 1));
        wait_n = 0;
        while (!req_ready_o && wait_n < 20) begin
            @(negedge clk_i);
            wait_n++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout actual=%b required=1", tag, req_ready_o);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_code_o !== ec || rsp_region_o !== er || rsp_rdata_o !== ed) begin
            failures++;
            $display("FAIL %s rsp addr=%h actual v=%b c=%b r=%0d d=%h required v=1 c=%b r=%0d d=%h",
                     tag, addr, rsp_valid_o, rsp_code_o, rsp_region_o, rsp_rdata_o, ec, er, ed);
        end
        if (lit[2]) begin
            checks++;
            if (rsp_code_o !== lit[1:0]) begin
                failures++;
                $display("FAIL %s literal_code actual=%b required=%b", tag, rsp_code_o, lit[1:0]);
            end
        end
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_in_resp actual=%b required=0", tag, req_ready_o);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_code_o !== ec || rsp_region_o !== er || rsp_rdata_o !== ed ||
                req_ready_o !== 1'b0 || err_cnt_o !== m_cnt) begin
                failures++;
                $display("FAIL %s stall%0d actual v=%b c=%b r=%0d d=%h rdy=%b cnt=%h required v=1 c=%b r=%0d d=%h rdy=0 cnt=%h",
                         tag, h, rsp_valid_o, rsp_code_o, rsp_region_o, rsp_rdata_o, req_ready_o, err_cnt_o,
                         ec, er, ed, m_cnt);
            end
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        clear_i     = clr;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        clear_i     = 1'b0;
`ifdef CARFIELD_DECERR_LOG_EN
        if (clr) begin
            m_cnt  = 16'h0000;
            m_last = 64'h0;
        end else if (ec != 2'b00) begin
            m_cnt  = (m_cnt == 16'hFFFF) ? 16'hFFFF : m_cnt + 16'd1;
            m_last = addr;
        end
`endif
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || err_cnt_o !== m_cnt || last_err_addr_o !== m_last) begin
            failures++;
            $display("FAIL %s done actual v=%b rdy=%b cnt=%h last=%h required v=0 rdy=1 cnt=%h last=%h",
                     tag, rsp_valid_o, req_ready_o, err_cnt_o, last_err_addr_o, m_cnt, m_last);
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 64'h7800_0000;
        req_write_i = 1'b0;
        rsp_ready_i = 1'b0;
        clear_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_code_o !== 2'b00 || rsp_region_o !== 3'd0 ||
            rsp_rdata_o !== 32'h0 || err_cnt_o !== 16'h0 || last_err_addr_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_values actual rdy=%b v=%b c=%b r=%0d d=%h cnt=%h last=%h required all 0",
                     req_ready_o, rsp_valid_o, rsp_code_o, rsp_region_o, rsp_rdata_o, err_cnt_o, last_err_addr_o);
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge actual=%b required=0", req_ready_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_release actual rdy=%b v=%b required rdy=1 v=0", req_ready_o, rsp_valid_o);
        end
    endtask

    task automatic test_directed();
        do_txn(64'h7800_0000, 0, 1'b0, 3'b100, "l2p0_ok");
        do_txn(64'h6000_0000, 0, 1'b0, 3'b101, "safety_disabled");
        do_txn(64'h783F_FFFC, 0, 1'b0, 3'b100, "l2p1_top_ok");
        do_txn(64'h7840_0000, 0, 1'b0, 3'b110, "l2p1_end_unmapped");
        do_txn(64'h4000_0002, 0, 1'b0, 3'b111, "mbox_misaligned");
        do_txn(64'h1_7800_0000, 0, 1'b0, 3'b110, "upper_bit_unmapped");
        do_txn(64'h2000_0FFC, 0, 1'b0, 3'b101, "eth_top_disabled");
        do_txn(64'h2000_1000, 0, 1'b0, 3'b100, "periph_base_ok");
    endtask

    task automatic test_stall();
        do_txn(64'h5000_0040, 5, 1'b0, 3'b101, "stall_error");
        do_txn(64'h5100_0000, 3, 1'b0, 3'b100, "stall_ok");
    endtask

    task automatic test_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
`ifdef CARFIELD_DECERR_LOG_EN
        m_cnt  = 16'h0000;
        m_last = 64'h0;
`endif
        checks++;
        if (err_cnt_o !== m_cnt || last_err_addr_o !== m_last) begin
            failures++;
            $display("FAIL clear_alone actual cnt=%h last=%h required cnt=%h last=%h",
                     err_cnt_o, last_err_addr_o, m_cnt, m_last);
        end
        do_txn(64'h9000_0000, 1, 1'b0, 3'b110, "after_clear_err");
        do_txn(64'h9000_0004, 0, 1'b1, 3'b110, "clear_coincident");
    endtask

    task automatic test_saturate();
`ifdef CARFIELD_DECERR_LOG_EN
        @(negedge clk_i);
        force dut.err_cnt_q = 16'hFFFF;
        @(posedge clk_i);
        #1;
        release dut.err_cnt_q;
        m_cnt = 16'hFFFF;
        do_txn(64'h6000_0000, 0, 1'b0, 3'b101, "saturate_hold");
        do_txn(64'h6000_0100, 0, 1'b1, 3'b101, "saturate_clear");
`else
        do_txn(64'h6000_0000, 0, 1'b0, 3'b101, "nolog_err");
        do_txn(64'h6000_0100, 0, 1'b1, 3'b101, "nolog_clear");
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            do_txn(rand_addr(), $urandom_range(0, 2), 1'($urandom_range(0, 15) == 0), 3'b000, "random");
        end
    endtask

    task automatic test_reset_in_resp();
        do_txn(64'h2000_0000, 0, 1'b0, 3'b101, "pre_reset_err");
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h7000_0000;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL resp_before_reset actual=%b required=1", rsp_valid_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        m_cnt  = 16'h0000;
        m_last = 64'h0;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || err_cnt_o !== 16'h0 || last_err_addr_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_in_resp actual v=%b rdy=%b cnt=%h last=%h required 0",
                     rsp_valid_o, req_ready_o, err_cnt_o, last_err_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || err_cnt_o !== 16'h0) begin
            failures++;
            $display("FAIL release_after_resp actual rdy=%b v=%b cnt=%h required rdy=1 v=0 cnt=0",
                     req_ready_o, rsp_valid_o, err_cnt_o);
        end
        do_txn(64'h7820_0000, 0, 1'b0, 3'b100, "post_reset_ok");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_clear();
        test_saturate();
        test_random();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carfield_decerr_resp.md
CARFIELD_DECERR_RESP -- requirements
Module: carfield_decerr_resp

Interface
REQ-001 The module SHALL have parameter AddrWidth, default 64, request address width.
REQ-002 The module SHALL have parameter DataWidth, default 32, read data width.
REQ-003 The module SHALL have parameter RegionEnable, 8 bits, default 8'b1011_0011, one enable bit per region index 7..0.
REQ-004 The module SHALL have parameter ErrData, default 32'hBADCAB1E, read data returned on every error response.
REQ-005 The module SHALL have port clk_i, input, 1 bit, the single clock.
REQ-006 The module SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-007 The module SHALL have port req_valid_i, input, 1 bit, request valid.
REQ-008 The module SHALL have port req_ready_o, output, 1 bit, request ready.
REQ-009 The module SHALL have port req_addr_i, input, AddrWidth bits, request byte address.
REQ-010 The module SHALL have port req_write_i, input, 1 bit, write flag, which is ignored for decode.
REQ-011 The module SHALL have port rsp_valid_o, output, 1 bit, response valid.
REQ-012 The module SHALL have port rsp_ready_i, input, 1 bit, response ready.
REQ-013 The module SHALL have port rsp_code_o, output, 2 bits: 00 OK, 01 DISABLED, 10 UNMAPPED, 11 MISALIGNED.
REQ-014 The module SHALL have port rsp_region_o, output, 3 bits, hit region index, 0 when the address is UNMAPPED.
REQ-015 The module SHALL have port rsp_rdata_o, output, DataWidth bits, response read data.
REQ-016 The module SHALL have port clear_i, input, 1 bit, single-cycle pulse that clears the error log.
REQ-017 The module SHALL have port err_cnt_o, output, 16 bits, saturating error count.
REQ-018 The module SHALL have port last_err_addr_o, output, AddrWidth bits, address of the most recent error response.

Function
REQ-019 The region map SHALL be half-open [base, base+size), using these base/size values:
- 0: L2 port0, 0x7800_0000 / 0x20_0000
- 1: L2 port1, 0x7820_0000 / 0x20_0000
- 2: safety island, 0x6000_0000 / 0x80_0000
- 3: ethernet, 0x2000_0000 / 0x1000
- 4: peripherals, 0x2000_1000 / 0x9000
- 5: Spatz, 0x5100_0000 / 0x80_0000
- 6: PULP, 0x5000_0000 / 0x80_0000
- 7: mailbox, 0x4000_0000 / 0x1000
REQ-020 On overlapping regions, the lowest region index SHALL win.
REQ-021 The FSM SHALL have two states, IDLE and RESP, and SHALL reset to IDLE.
REQ-022 req_ready_o SHALL be high only in IDLE.
REQ-023 A request handshake (req_valid_i && req_ready_o) SHALL register code, region, rdata and address, and move the FSM to RESP.
REQ-024 rsp_valid_o SHALL be high exactly while in RESP, so the response appears one cycle after acceptance.
REQ-025 All response outputs SHALL hold stable while rsp_valid_o && !rsp_ready_i.
REQ-026 A response handshake SHALL return the FSM to IDLE, giving a maximum throughput of one transaction per two cycles.
REQ-027 Decode priority SHALL be: MISALIGNED if req_addr_i[1:0] != 0; else DISABLED if a region with a clear enable bit is hit; else OK if an enabled region is hit; else UNMAPPED.
REQ-028 An OK response SHALL carry rsp_rdata_o = 0; every other code SHALL carry rsp_rdata_o = ErrData.
REQ-029 Each error response handshake (code != OK) SHALL increment err_cnt_o, saturating at 0xFFFF, and SHALL load last_err_addr_o with the captured address.
REQ-030 clear_i SHALL zero err_cnt_o and last_err_addr_o on the next edge; when it coincides with an error handshake, clear SHALL win and both results SHALL be 0.
REQ-031 Address bits above bit 31 SHALL participate in decode, so any nonzero upper bit yields UNMAPPED.

Reset
REQ-032 While rst_ni is low, the FSM SHALL be IDLE and req_ready_o SHALL be 0.
REQ-033 While rst_ni is low, rsp_valid_o, rsp_code_o, rsp_region_o, rsp_rdata_o, err_cnt_o and last_err_addr_o SHALL all be 0.
REQ-034 Reset asserted in RESP SHALL drop the pending response without counting it.
REQ-035 req_ready_o SHALL rise on the first clock edge after rst_ni deasserts.

Configuration
REQ-036 With macro CARFIELD_DECERR_LOG_EN defined, the error counter and address capture SHALL be implemented per REQ-029/REQ-030.
REQ-037 Without CARFIELD_DECERR_LOG_EN, err_cnt_o and last_err_addr_o SHALL be constant 0, clear_i SHALL be ignored, and no log flops SHALL exist; response behaviour is unchanged.

Verification
REQ-038 Read 0x7800_0000 -> after 1 cycle rsp_code_o=00, rsp_region_o=0, rsp_rdata_o=0, err_cnt_o unchanged.
REQ-039 Read 0x6000_0000 with the default RegionEnable -> code 01, region 2, rdata 0xBADCAB1E, err_cnt_o=1, last_err_addr_o=0x6000_0000.
REQ-040 Boundary: 0x783F_FFFC -> OK region 1; 0x7840_0000 -> UNMAPPED region 0; 0x4000_0002 -> MISALIGNED.
REQ-041 Hold rsp_ready_i low for 5 cycles after an error request -> outputs stable, req_ready_o=0, counter incremented once only at the handshake.
REQ-042 Preload the count at 0xFFFF, then issue an error request -> count stays 0xFFFF; clear_i coincident with an error handshake -> count 0, address 0.
REQ-043 Assert rst_ni low while in RESP -> rsp_valid_o=0 immediately; after release, req_ready_o=1 and err_cnt_o=0.
